// File: rtl/rom_rd_master_pkg.sv
// -----------------------------------------------------------------------------
// rom_rd_master_pkg
//   Shared definitions for the ROM/bus read master:
//     - state_t         : FSM state encodings (IDLE / BUS / TURN)
//     - DEFAULT_TIMEOUT : default watchdog length, in cycles, for a bus read
//     - ENABLE_/DISABLE_: levels of the active-low cs_/as_/rdy_ bus signals
// -----------------------------------------------------------------------------
package rom_rd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a fetch request
    ST_BUS  = 2'd1,  // strobe asserted, waiting for rdy_
    ST_TURN = 2'd2   // strobe released for one cycle between reads
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  // Asserted and deasserted levels of the active-low bus strobes.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage : rom_rd_master_pkg

// File: rtl/rom_rd_master.sv
// -----------------------------------------------------------------------------
// rom_rd_master
//   Issues single-word reads on the active-low cs_/as_/rdy_ bus on behalf of
//   the instruction-fetch unit. A request is registered onto the bus, the
//   master waits for the slave's rdy_, captures rd_data and returns it with a
//   one-cycle done pulse. A watchdog aborts the read (done with err) when rdy_
//   has not arrived within TIMEOUT strobe cycles.
//
// Parameters
//   ADDR_W   word address width on the bus
//   DATA_W   read data width
//   TIMEOUT  strobe cycles to wait for rdy_ before aborting (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   req        fetch unit read request, accepted when req && req_ready
//   req_addr   word address, sampled on acceptance
//   req_ready  master can accept a request this cycle
//   done       one-cycle pulse: read finished (data or error)
//   err        valid with done: read aborted by the watchdog
//   data_out   read data, valid with done, held until the next done
//   cs_        chip select, active-low, registered
//   as_        address strobe, active-low, registered
//   addr       bus address, registered
//   rd_data    slave read data
//   rdy_       slave ready, active-low
// -----------------------------------------------------------------------------
module rom_rd_master
  import rom_rd_master_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic              cs_,
  output logic              as_,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  // Wait counter only has to reach TIMEOUT-1, so ceil(log2(TIMEOUT)) bits.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Accepting is allowed everywhere except while a strobe is outstanding;
  // TURN accepts so back-to-back reads sustain one per three cycles.
  assign req_ready = (state != ST_BUS);

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cs_      <= DISABLE_;
      as_      <= DISABLE_;
      addr     <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // NOTE: done/err default low each cycle, which makes them single-cycle
      // pulses without needing a separate clear path.
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        // IDLE and TURN behave alike: the strobe is already high, rdy_ is
        // ignored (in TURN it is still the slave's answer to the last read).
        ST_IDLE, ST_TURN: begin
          if (req) begin
            addr     <= req_addr;
            cs_      <= ENABLE_;
            as_      <= ENABLE_;
            wait_cnt <= '0;
            state    <= ST_BUS;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_BUS: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (rdy_ == ENABLE_) begin
            data_out <= rd_data;
            done     <= 1'b1;
            cs_      <= DISABLE_;
            as_      <= DISABLE_;
            state    <= ST_TURN;
          end else if (wait_cnt == CNT_LAST) begin
            data_out <= '0;
            done     <= 1'b1;
            err      <= 1'b1;
            cs_      <= DISABLE_;
            as_      <= DISABLE_;
            state    <= ST_TURN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          cs_   <= DISABLE_;
          as_   <= DISABLE_;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : rom_rd_master

// File: doc/rom_rd_master.md
# rom_rd_master

Bus initiator that issues single-word reads to an active-low-handshake memory slave (the instruction ROM and any other slave on the same cs_/as_/rdy_ bus) on behalf of a fetch unit. It registers the request, drives chip select, address strobe and address, waits for the slave's ready, captures the read data, and returns it with a one-cycle done pulse. A watchdog aborts reads whose ready never arrives. It sits between the instruction-fetch stage and the bus.

## Interface
- ADDR_W, 11, word address width on the bus
- DATA_W, 32, read data width
- TIMEOUT, 15, maximum cycles to wait for rdy_ before aborting (≥2)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  fetch unit requests a read; accepted when req && req_ready
- req_addr  in  ADDR_W  word address, sampled on acceptance
- req_ready  out  1  block can accept a request this cycle
- done  out  1  one-cycle pulse: read finished (data or error)
- err  out  1  valid with done: read aborted by timeout
- data_out  out  DATA_W  read data, valid with done; holds until next done
- cs_  out  1  chip select, active-low, registered
- as_  out  1  address strobe, active-low, registered
- addr  out  ADDR_W  bus address, registered
- rd_data  in  DATA_W  slave read data
- rdy_  in  1  slave ready, active-low

## Operation
- States: IDLE, BUS, TURN.
- IDLE: req_ready=1. On req: latch req_addr into addr, drive cs_=as_=0 next cycle, clear wait counter, go BUS.
- BUS: cs_=as_=0, addr stable, req_ready=0. Each cycle sample rdy_:
  - rdy_=0: capture rd_data into data_out, raise cs_/as_ high next cycle, pulse done with err=0, go TURN.
  - rdy_=1 and counter = TIMEOUT−1: raise cs_/as_, data_out←0, pulse done with err=1, go TURN.
  - else counter+1.
- TURN: cs_=as_=1. rdy_ is ignored, because the slave still reports ready for the previous strobe. req_ready=1. On req, load the new address and go BUS. Otherwise go IDLE.
- Counter is ceil(log2(TIMEOUT)) bits and never wraps. It saturates at the abort condition.
- req while req_ready=0 is ignored. The fetch unit holds req until accepted.
- rdy_=0 in IDLE is ignored.

## Timing
- Reset values (on the edge with reset=1, regardless of state): state=IDLE, cs_=1, as_=1, addr=0, data_out=0, done=0, err=0, counter=0. Reset mid-read drops the strobe on the next edge. No done is issued for the killed read.
- Read against the zero-wait slave:
  - cycle 0: req accepted.
  - cycle 1: cs_/as_ low.
  - cycle 2: rdy_ low, data sampled at end of cycle.
  - cycle 3: done=1, data_out valid, cs_/as_ high.
- Latency from acceptance to done is 3 cycles for the zero-wait slave, plus one cycle per slave wait cycle.
- Back-to-back: a request accepted in TURN (cycle 3) strobes in cycle 4. Sustained rate is one read per 3 cycles. as_ is always high for at least one cycle between reads.
- Timeout: with rdy_ stuck high, done/err rise TIMEOUT+1 cycles after acceptance. cs_/as_ are low for exactly TIMEOUT cycles.
- rdy_=0 and the timeout condition in the same cycle: ready wins, err=0.
- done and err are registered, one cycle wide, and never asserted in consecutive cycles.

## Structure
- Shared header: the state encodings (IDLE/BUS/TURN) and a bus-master header holding the default TIMEOUT.
- Active-low ENABLE_/DISABLE_ levels come from the existing common definitions header.
- Single module. The counter and FSM are small enough that no sub-module is warranted.

## Test plan
- Single read at addr 0x005, slave returns 0xDEADBEEF, zero wait:
  - done=1 exactly 3 cycles after acceptance, err=0, data_out=0xDEADBEEF.
  - cs_/as_ low for exactly 2 cycles.
- Back-to-back reads to 0x000, 0x001, 0x002 with req held high:
  - done pulses spaced 3 cycles apart with correct data.
  - as_ high for ≥1 cycle between strobes.
  - The stale rdy_=0 during TURN causes no extra done.
- Slave with 4 wait cycles, data 0x12345678: done 7 cycles after acceptance, err=0, addr stable throughout BUS.
- rdy_ held high, TIMEOUT=15:
  - done=1, err=1, data_out=0 at cycle 16.
  - cs_ low for 15 cycles.
  - A following normal read succeeds.
- reset=1 asserted for one cycle in the second BUS cycle:
  - Next cycle cs_=as_=1, state IDLE, no done.
  - A new request completes normally.
- rdy_ pulsed low while IDLE: no done, no state change.
